flog_unit: RTL and testbench
============================

# flog_unit

Parametrised floating-point base-2 logarithm unit: accepts one IEEE-style operand (sign/exponent/mantissa) through a valid/ready handshake, classifies it, computes log2(1.m) with a bit-serial square-and-compare engine, adds the unbiased exponent and renormalises the fixed-point sum into the same float format. It is the next-generation flog datapath block: generic in exponent, mantissa and iteration width, with special-value handling, status flags and output backpressure. It sits between the operand source and the result consumer; bfloat16 is the default configuration.

## Interface
- EXP_WIDTH, 8, exponent field width
- MAN_WIDTH, 7, stored mantissa width (hidden bit not included)
- LOG_BITS, 16, fractional log bits produced; must be ≥ MAN_WIDTH+3
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  unit can accept operand (high only in IDLE)
- in_sign  input  1  operand sign
- in_exp  input  EXP_WIDTH  biased exponent
- in_man  input  MAN_WIDTH  mantissa
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- out_sign / out_exp / out_man  output  1 / EXP_WIDTH / MAN_WIDTH  result fields
- out_invalid  output  1  result is NaN from negative or NaN input
- out_dbz  output  1  result is −inf from zero input

## Operation
- BIAS = 2^(EXP_WIDTH−1)−1; EMAX = all-ones exponent.
- States: IDLE, ITER, NORM, DONE.
- IDLE: in_ready=1. On in_valid: register operand, classify:
  - exp=0 (zero or subnormal, either sign; subnormals flushed) → −inf {1,EMAX,0}, out_dbz=1 → DONE.
  - exp=EMAX, man≠0 → canonical NaN {0,EMAX,1<<(MAN_WIDTH−1)}, out_invalid=1 → DONE.
  - sign=1, finite nonzero → canonical NaN, out_invalid=1 → DONE.
  - +inf → +inf → DONE.
  - exp=BIAS, man=0 → +0 → DONE.
  - otherwise start engine with 1.man, k = exp−BIAS (signed, EXP_WIDTH+1 bits) → ITER.
- ITER: engine emits one fraction bit per cycle, MSB first: y←y² (Q2.W, truncated); if y≥2 bit=1, y←y/2. After LOG_BITS bits → NORM.
- NORM: V = {k, f} signed fixed point (EXP_WIDTH+1 int, LOG_BITS frac). out_sign = V<0; M = |V|; p = leading-one index; out_exp = BIAS + p − LOG_BITS; out_man = next MAN_WIDTH bits below leading one (padded with zeros if fewer). M=0 → +0. → DONE.
- DONE: out_valid=1, outputs stable; on out_ready → IDLE, out_valid falls next cycle.
- Result exponent never overflows (|V| < 2^EXP_WIDTH−1); no output inf from finite input.

## Timing
- Reset: out_valid, out_sign, out_exp, out_man, out_invalid, out_dbz = 0; state IDLE, so in_ready=1 throughout reset.
- Acceptance edge = cycle 0. Special cases: out_valid at cycle 1. Normal: out_valid at cycle LOG_BITS+2 (18 default).
- No input accepted while busy; in_valid ignored outside IDLE.
- out_ready may be high before out_valid; result consumed on first cycle both high. Next operand accepted earliest one cycle after consumption.
- Reset mid-operation aborts immediately; no partial result emitted.
- Flags are valid only with out_valid and clear on return to IDLE.

## Configuration
- FLOG_RNE_EN defined: NORM rounds to nearest-even using guard and sticky bits of M; mantissa carry-out increments out_exp and clears out_man.
- Undefined: out_man truncated. Latency identical in both builds.

## Structure
- flog_pkg: BIAS/EMAX derivation functions, state enum, class enum (ZERO, NAN, NEG, INF, ONE, NORMAL), canonical NaN/inf constants.
- Sub-module log2_frac_seq: start/done, 1.m input, LOG_BITS-bit fraction output, internal width MAN_WIDTH+LOG_BITS.
- Leading-one detect and rounding inline in flog_unit.

## Test plan
- 0x4000 (2.0) → 0x3F80, 18 cycles; 0x4100 (8.0) → 0x4040; 0x3F00 (0.5) → 0xBF80.
- 0x3F80 (1.0) → 0x0000 at cycle 1; 0x7F80 → 0x7F80; no flags.
- 0x0000 and 0x8000 → 0xFF80, out_dbz=1; 0xBF80 and 0x7FC1 → 0x7FC0, out_invalid=1.
- 0x4040 (3.0) → 0x3FCB with FLOG_RNE_EN, 0x3FCA without.
- out_ready low 10 cycles after out_valid: outputs held, in_ready=0, new in_valid ignored; consumed on release, next operand accepted following cycle.
- rst asserted in ITER: all outputs 0 immediately, in_ready=1; subsequent 2.0 returns 0x3F80 with correct latency.

Source files
------------

// File: rtl/flog_pkg.sv
// flog_pkg: shared state/class enums, format-derivation helpers and canonical
// special-value constants for the flog_unit log2 datapath.
package flog_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_NORM, S_DONE} state_e;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NAN,
        CLS_NEG,
        CLS_INF,
        CLS_ONE,
        CLS_NORMAL
    } class_e;

    localparam logic NAN_SIGN  = 1'b0;
    localparam logic NINF_SIGN = 1'b1;
    localparam logic PINF_SIGN = 1'b0;

    function automatic int flog_bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    function automatic int flog_emax(input int exp_width);
        return (1 << exp_width) - 1;
    endfunction

    // Canonical NaN carries only the quiet bit in its mantissa.
    function automatic int flog_nan_man(input int man_width);
        return 1 << (man_width - 1);
    endfunction

    function automatic class_e flog_classify(
        input logic sign,
        input logic exp_zero,
        input logic exp_max,
        input logic man_zero,
        input logic exp_bias
    );
        if (exp_zero)
            return CLS_ZERO;
        if (exp_max && !man_zero)
            return CLS_NAN;
        if (sign)
            return CLS_NEG;
        if (exp_max)
            return CLS_INF;
        if (exp_bias && man_zero)
            return CLS_ONE;
        return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/log2_frac_seq.sv
// log2_frac_seq: bit-serial log2(1.m) engine; one fraction bit per cycle, MSB first,
// by repeated truncated squaring of y (Q2 fixed point) with renormalisation when y >= 2.
module log2_frac_seq #(
    parameter int MAN_WIDTH = 7,
    parameter int LOG_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MAN_WIDTH:0]   mant,
    output logic                 done,
    output logic [LOG_BITS-1:0]  frac
);

    localparam int FW = MAN_WIDTH + LOG_BITS;
    localparam int YW = FW + 2;
    localparam int SW = 2 * YW;
    localparam int CW = $clog2(LOG_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(LOG_BITS - 1);

    logic                busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [YW-1:0]       y_q, y_d;
    logic [LOG_BITS-1:0] frac_q, frac_d;
    logic [YW-1:0]       sq;
    logic                bit_out;

    always_comb begin
        sq      = YW'((SW'(y_q) * SW'(y_q)) >> FW);
        bit_out = sq[YW-1];
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        frac_d  = frac_q;
        done    = busy_q && (cnt_q == LAST);
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            y_d    = {1'b0, mant, {LOG_BITS{1'b0}}};
        end else if (busy_q) begin
            y_d    = bit_out ? (sq >> 1) : sq;
            frac_d = {frac_q[LOG_BITS-2:0], bit_out};
            cnt_d  = cnt_q + 1'b1;
            if (done)
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        y_q    <= y_d;
        frac_q <= frac_d;
    end

    assign frac = frac_q;

endmodule

// File: rtl/flog_unit.sv
// flog_unit: floating-point log2 (classify, serial fraction engine, renormalise).
// Build option FLOG_RNE_EN: round-to-nearest-even in NORM instead of truncation.
module flog_unit
    import flog_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 7,
    parameter int LOG_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic [MAN_WIDTH-1:0] in_man,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic [MAN_WIDTH-1:0] out_man,
    output logic                 out_invalid,
    output logic                 out_dbz
);

    localparam int BIAS_I = flog_bias(EXP_WIDTH);
    localparam logic [EXP_WIDTH-1:0] BIAS_V  = EXP_WIDTH'(BIAS_I);
    localparam logic [EXP_WIDTH-1:0] EMAX_V  = EXP_WIDTH'(flog_emax(EXP_WIDTH));
    localparam logic [MAN_WIDTH-1:0] NAN_MAN = MAN_WIDTH'(flog_nan_man(MAN_WIDTH));
    localparam int KW = EXP_WIDTH + 1;
    localparam int VW = KW + LOG_BITS;
    localparam int PW = $clog2(VW);

    state_e                 state_q, state_d;
    logic signed [KW-1:0]   k_q, k_d;
    logic                   valid_q, valid_d;
    logic                   sign_q, sign_d;
    logic [EXP_WIDTH-1:0]   exp_q, exp_d;
    logic [MAN_WIDTH-1:0]   man_q, man_d;
    logic                   inv_q, inv_d;
    logic                   dbz_q, dbz_d;

    class_e                 cls;
    logic                   eng_start;
    logic                   eng_done;
    logic [LOG_BITS-1:0]    frac;

    logic signed [VW-1:0]   v;
    logic [VW-1:0]          m_abs;
    logic [PW-1:0]          lead;
    logic [EXP_WIDTH-1:0]   n_exp;
    logic [MAN_WIDTH-1:0]   n_man;

    log2_frac_seq #(
        .MAN_WIDTH (MAN_WIDTH),
        .LOG_BITS  (LOG_BITS)
    ) u_frac (
        .clk   (clk),
        .rst   (rst),
        .start (eng_start),
        .mant  ({1'b1, in_man}),
        .done  (eng_done),
        .frac  (frac)
    );

    assign cls = flog_classify(in_sign, in_exp == '0, in_exp == EMAX_V,
                               in_man == '0, in_exp == BIAS_V);

`ifdef FLOG_RNE_EN
    logic [VW-2:0] nrm;

    // nrm has the leading one already stripped; result is {exp, man}.
    function automatic logic [EXP_WIDTH+MAN_WIDTH-1:0] round_rne(
        input logic [VW-2:0] n,
        input logic [PW-1:0] p
    );
        logic [MAN_WIDTH-1:0] m;
        logic                 guard;
        logic                 sticky;
        logic [MAN_WIDTH:0]   sum;
        logic [EXP_WIDTH-1:0] e;
        m      = n[VW-2 -: MAN_WIDTH];
        guard  = n[VW-2-MAN_WIDTH];
        sticky = |n[VW-3-MAN_WIDTH:0];
        sum    = {1'b0, m} + (MAN_WIDTH+1)'(guard && (sticky || m[0]));
        e      = EXP_WIDTH'(BIAS_I + int'(p) - LOG_BITS) + EXP_WIDTH'(sum[MAN_WIDTH]);
        return {e, sum[MAN_WIDTH-1:0]};
    endfunction
`endif

    always_comb begin
        v     = {k_q, frac};
        m_abs = v[VW-1] ? $unsigned(-v) : $unsigned(v);
        lead  = '0;
        for (int i = 0; i < VW; i++)
            if (m_abs[i])
                lead = PW'(i);
`ifdef FLOG_RNE_EN
        nrm            = (VW-1)'(m_abs << (VW - 1 - int'(lead)));
        {n_exp, n_man} = round_rne(nrm, lead);
`else
        n_man = MAN_WIDTH'((m_abs << (VW - 1 - int'(lead))) >> (VW - 1 - MAN_WIDTH));
        n_exp = EXP_WIDTH'(BIAS_I + int'(lead) - LOG_BITS);
`endif
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        valid_d   = valid_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        man_d     = man_q;
        inv_d     = inv_q;
        dbz_d     = dbz_q;
        eng_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (cls == CLS_NORMAL) begin
                        k_d       = $signed({1'b0, in_exp}) - $signed({1'b0, BIAS_V});
                        eng_start = 1'b1;
                        state_d   = S_ITER;
                    end else begin
                        valid_d = 1'b1;
                        state_d = S_DONE;
                        man_d   = '0;
                        case (cls)
                            CLS_ZERO: begin
                                sign_d = NINF_SIGN;
                                exp_d  = EMAX_V;
                                dbz_d  = 1'b1;
                            end
                            CLS_NAN, CLS_NEG: begin
                                sign_d = NAN_SIGN;
                                exp_d  = EMAX_V;
                                man_d  = NAN_MAN;
                                inv_d  = 1'b1;
                            end
                            CLS_INF: begin
                                sign_d = PINF_SIGN;
                                exp_d  = EMAX_V;
                            end
                            default: begin
                                sign_d = 1'b0;
                                exp_d  = '0;
                            end
                        endcase
                    end
                end
            end
            S_ITER: begin
                if (eng_done)
                    state_d = S_NORM;
            end
            S_NORM: begin
                valid_d = 1'b1;
                state_d = S_DONE;
                if (m_abs == '0) begin
                    sign_d = 1'b0;
                    exp_d  = '0;
                    man_d  = '0;
                end else begin
                    sign_d = v[VW-1];
                    exp_d  = n_exp;
                    man_d  = n_man;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    inv_d   = 1'b0;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            inv_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            man_q   <= man_d;
            inv_q   <= inv_d;
            dbz_q   <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        k_q <= k_d;
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = valid_q;
    assign out_sign    = sign_q;
    assign out_exp     = exp_q;
    assign out_man     = man_q;
    assign out_invalid = inv_q;
    assign out_dbz     = dbz_q;

endmodule

// File: tb/tb_flog_unit.sv
// tb_flog_unit: vector table, random operands against a log2 reference model,
// backpressure and mid-operation reset sequences for flog_unit (bfloat16 build).
module tb_flog_unit;

    localparam int EW = 8;
    localparam int MW = 7;
    localparam int LB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic [EW-1:0] in_exp = '0;
    logic [MW-1:0] in_man = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [MW-1:0] out_man;
    logic          out_invalid;
    logic          out_dbz;

    int checks   = 0;
    int failures = 0;

    flog_unit #(.EXP_WIDTH(EW), .MAN_WIDTH(MW), .LOG_BITS(LB)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_man      (in_man),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_exp     (out_exp),
        .out_man     (out_man),
        .out_invalid (out_invalid),
        .out_dbz     (out_dbz)
    );

    always #5 clk = ~clk;

`ifdef FLOG_RNE_EN
    localparam logic [15:0] THREE_RES = 16'h3FCB;
`else
    localparam logic [15:0] THREE_RES = 16'h3FCA;
`endif

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        logic        inv;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] result_word();
        return {out_sign, out_exp, out_man};
    endfunction

    // log2 of a bfloat16 operand: special cases by value class, otherwise
    // log2(x) = (e - bias) + log2(1.m), the fraction found by squaring 1.m.
    function automatic void model(input logic [15:0] op, output logic [15:0] res,
                                  output logic inv, output logic dbz, output int lat);
        int ex, mn, k, p, rex, rmn;
        logic sg;
        longint unsigned y, mabs;
        longint f, v;
        sg  = op[15];
        ex  = int'(op[14:7]);
        mn  = int'(op[6:0]);
        inv = 1'b0;
        dbz = 1'b0;
        lat = 1;
        res = 16'h0000;
        if (ex == 0) begin
            res = 16'hFF80; dbz = 1'b1; return;
        end
        if ((ex == 255 && mn != 0) || sg) begin
            res = 16'h7FC0; inv = 1'b1; return;
        end
        if (ex == 255) begin
            res = 16'h7F80; return;
        end
        if (ex == 127 && mn == 0)
            return;
        lat = LB + 2;
        k   = ex - 127;
        y   = longint'(128 + mn) << LB;
        f   = 0;
        for (int i = 0; i < LB; i++) begin
            y = (y * y) >> (MW + LB);
            f = f * 2;
            if (y >= (64'd2 << (MW + LB))) begin
                f = f + 1;
                y = y >> 1;
            end
        end
        v = longint'(k) * (longint'(1) << LB) + f;
        if (v == 0)
            return;
        mabs = (v < 0) ? longint'(-v) : longint'(v);
        p = 0;
        for (int i = 0; i < 63; i++)
            if (mabs[i])
                p = i;
        rex = 127 + p - LB;
        if (p >= MW)
            rmn = int'((mabs >> (p - MW)) & 64'd127);
        else
            rmn = int'((mabs << (MW - p)) & 64'd127);
`ifdef FLOG_RNE_EN
        if (p > MW) begin
            logic guard, sticky;
            guard  = ((mabs >> (p - MW - 1)) & 64'd1) != 0;
            sticky = (mabs & ((64'd1 << (p - MW - 1)) - 64'd1)) != 0;
            if (guard && (sticky || (rmn % 2 == 1))) begin
                rmn++;
                if (rmn == 128) begin
                    rmn = 0;
                    rex++;
                end
            end
        end
`endif
        res = {(v < 0), rex[7:0], rmn[6:0]};
    endfunction

    // Called at the phase 1 time unit after a rising edge.
    task automatic run_op(input string name, input logic [15:0] op, input logic [15:0] eres,
                          input logic einv, input logic edbz, input int elat);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        {in_sign, in_exp, in_man} = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LB + 20) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_lat"}, 32'(lat), 32'(elat));
        check({name, "_res"}, 32'(result_word()), 32'(eres));
        check({name, "_inv"}, 32'(out_invalid), 32'(einv));
        check({name, "_dbz"}, 32'(out_dbz), 32'(edbz));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_vfall"}, 32'(out_valid), 32'd0);
        check({name, "_flagclr"}, 32'({out_invalid, out_dbz}), 32'd0);
    endtask

    initial begin
        vec_t tbl [12];
        logic [15:0] op, eres;
        logic einv, edbz;
        int elat;

        tbl[0]  = '{16'h4000, 16'h3F80, 1'b0, 1'b0, 18};
        tbl[1]  = '{16'h4100, 16'h4040, 1'b0, 1'b0, 18};
        tbl[2]  = '{16'h3F00, 16'hBF80, 1'b0, 1'b0, 18};
        tbl[3]  = '{16'h4080, 16'h4000, 1'b0, 1'b0, 18};
        tbl[4]  = '{16'h3F80, 16'h0000, 1'b0, 1'b0, 1};
        tbl[5]  = '{16'h7F80, 16'h7F80, 1'b0, 1'b0, 1};
        tbl[6]  = '{16'h0000, 16'hFF80, 1'b0, 1'b1, 1};
        tbl[7]  = '{16'h8000, 16'hFF80, 1'b0, 1'b1, 1};
        tbl[8]  = '{16'h0001, 16'hFF80, 1'b0, 1'b1, 1};
        tbl[9]  = '{16'hBF80, 16'h7FC0, 1'b1, 1'b0, 1};
        tbl[10] = '{16'h7FC1, 16'h7FC0, 1'b1, 1'b0, 1};
        tbl[11] = '{16'h4040, THREE_RES, 1'b0, 1'b0, 18};

        // reset state, with in_valid asserted to show nothing is taken in reset
        in_valid = 1'b1;
        {in_sign, in_exp, in_man} = 16'h4000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_res", 32'(result_word()), 32'd0);
        check("rst_flags", 32'({out_invalid, out_dbz}), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].res, tbl[i].inv, tbl[i].dbz, tbl[i].lat);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) != 0)
                op = {1'b0, 8'($urandom_range(96, 160)), 7'($urandom)};
            else
                op = 16'($urandom);
            model(op, eres, einv, edbz, elat);
            run_op($sformatf("rnd%0d_%04h", i, op), op, eres, einv, edbz, elat);
        end

        // backpressure: result held for 10 cycles while a new operand is offered
        in_valid = 1'b1;
        {in_sign, in_exp, in_man} = 16'h4100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        elat = 1;
        while (!out_valid && elat < LB + 20) begin
            @(posedge clk); #1; elat++;
        end
        check("bp_lat", 32'(elat), 32'd18);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            {in_sign, in_exp, in_man} = 16'h3F80;
            check($sformatf("bp_valid%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp_res%0d", c), 32'(result_word()), 32'h4040);
            check($sformatf("bp_ready%0d", c), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_consumed", 32'(out_valid), 32'd0);
        check("bp_idle", 32'(in_ready), 32'd1);
        run_op("bp_next", 16'h4000, 16'h3F80, 1'b0, 1'b0, 18);

        // reset while the engine is iterating
        in_valid = 1'b1;
        {in_sign, in_exp, in_man} = 16'h4000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("iter_busy", 32'(in_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_res", 32'(result_word()), 32'd0);
        check("mid_rst_flags", 32'({out_invalid, out_dbz}), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_novalid", 32'(out_valid), 32'd0);
        run_op("post_rst", 16'h4000, 16'h3F80, 1'b0, 1'b0, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
